// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states, default sizes.
package exec_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 6;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, low WIDTH bits of the product.
// start loads the operands; one iteration per clock while busy. done is
// high during the cycle of the final iteration, and product carries the
// accumulator value that this final iteration produces, so the caller can
// capture the finished result on the same edge.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] acc_next;

    // Conditional add of the shifted multiplicand for the current multiplier bit.
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    // Operand load on start, then one shift-add iteration per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            acc_reg    <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    assign product = acc_next;

endmodule

// File: rtl/exec_unit.sv
// Execute stage feeding the register bank write port: single-cycle ALU ops
// plus an iterative multiply, with a valid/ready input handshake.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  OperandA,
    input  logic [WIDTH-1:0]  OperandB,
    input  logic [ADDR_W-1:0] DestReg,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [WIDTH-1:0]  writeData,
    output logic              regWrite,
    output logic              Zero,
    output logic              done,
    output logic              illegal
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] dest_reg;

    logic              accept;
    logic [WIDTH-1:0]  alu_result;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [WIDTH-1:0]  mul_product;

    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic [ADDR_W-1:0] load_dest;
    logic              load_illegal;

    assign in_ready = (state_reg == S_IDLE);
    assign accept   = in_valid && in_ready;

    seq_multiplier #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (OperandA),
        .b       (OperandB),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle ALU; MUL and the reserved opcode produce 0 here.
    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = OperandA + OperandB;
            OP_SUB:  alu_result = OperandA - OperandB;
            OP_AND:  alu_result = OperandA & OperandB;
            OP_OR:   alu_result = OperandA | OperandB;
            OP_NOR:  alu_result = ~(OperandA | OperandB);
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(OperandA) < $signed(OperandB))};
            default: alu_result = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus the result-capture controls for entering DONE.
    always_comb begin
        state_next   = state_reg;
        mul_start    = 1'b0;
        load         = 1'b0;
        load_value   = alu_result;
        load_dest    = DestReg;
        load_illegal = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_next = S_MUL;
                        mul_start  = 1'b1;
                    end else begin
                        state_next   = S_DONE;
                        load         = 1'b1;
                        load_illegal = (op == OP_RSVD);
                    end
                end
            end
            S_MUL: begin
                load_dest  = dest_reg;
                load_value = mul_product;
                if (mul_done) begin
                    state_next = S_DONE;
                    load       = 1'b1;
                end else if (!mul_busy) begin
                    // Multiplier not running: nothing to wait for, recover.
                    state_next = S_IDLE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Destination capture at accept, held for the duration of a multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dest_reg <= '0;
        end else if (accept) begin
            dest_reg <= DestReg;
        end
    end

    // Write-back registers: loaded on entry to DONE, strobes last one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WriteReg  <= '0;
            writeData <= '0;
            regWrite  <= 1'b0;
            Zero      <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            regWrite <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            if (load) begin
                WriteReg  <= load_dest;
                writeData <= load_value;
                Zero      <= (load_value == '0);
                done      <= 1'b1;
                illegal   <= load_illegal;
                regWrite  <= !load_illegal && (load_dest != '0);
            end
        end
    end

endmodule
